// File: rtl/rf_ctrl_pkg.sv
// Shared types and sizes for the register-file write-side control logic.
// DataWidth here is the default data width used by wb_req_t.
package rf_ctrl_pkg;

   localparam int RegAddrWidth = 5;
   localparam int RegsNum      = 32;
   parameter  int DataWidth    = 32;

   typedef logic [RegAddrWidth-1:0] reg_addr_t;

   typedef struct packed {
      reg_addr_t            wreg;
      logic [DataWidth-1:0] wdata;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first requester at or after ptr,
// wrapping modulo N, wins; gr is one-hot or all zero.
module rr_arbiter #(
   parameter  int N    = 3,
   localparam int PtrW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [PtrW-1:0] ptr,
   output logic [N-1:0]    gr
);

   logic [PtrW-1:0] idx;
   logic            found;

   always_comb begin
      gr    = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = PtrW'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            gr[idx] = 1'b1;
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin sharing of the register-file write port between NumSrc writeback sources,
// with a registered write stage. Macro RF_WB_SCOREBOARD_EN adds a per-register pending scoreboard.
module rf_wb_arbiter
   import rf_ctrl_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int NumSrc    = 3
) (
   input  logic                             i_clk,
   input  logic                             i_rstn,
   input  logic [NumSrc-1:0]                i_src_valid,
   output logic [NumSrc-1:0]                o_src_ready,
   input  reg_addr_t [NumSrc-1:0]           i_src_wreg,
   input  logic [NumSrc-1:0][DataWidth-1:0] i_src_wdata,
   output reg_addr_t                        o_wreg,
   output logic [DataWidth-1:0]             o_wdata,
   output logic                             o_we,
   input  logic                             i_rsv_valid,
   input  reg_addr_t                        i_rsv_reg,
   output logic [RegsNum-1:0]               o_pending
);

   localparam int PtrW = $clog2(NumSrc);

   logic [PtrW-1:0]      rr_ptr_q;
   logic [PtrW-1:0]      rr_ptr_d;
   logic [NumSrc-1:0]    req;
   logic [NumSrc-1:0]    gnt;
   logic                 hs;
   logic [PtrW-1:0]      gnt_idx;
   reg_addr_t            sel_wreg;
   logic [DataWidth-1:0] sel_wdata;

   // Masking requests during reset keeps any handshake from completing in a reset cycle.
   assign req = i_rstn ? i_src_valid : '0;

   rr_arbiter #(.N(NumSrc)) u_rr_arbiter (
      .req (req),
      .ptr (rr_ptr_q),
      .gr  (gnt)
   );

   assign o_src_ready = gnt;
   assign hs          = |gnt;

   always_comb begin
      gnt_idx   = '0;
      sel_wreg  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NumSrc; i++) begin
         if (gnt[i]) begin
            gnt_idx   = PtrW'(i);
            sel_wreg  = i_src_wreg[i];
            sel_wdata = i_src_wdata[i];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (hs) begin
         rr_ptr_d = (gnt_idx == PtrW'(NumSrc - 1)) ? '0 : gnt_idx + PtrW'(1);
      end
   end

   // x0 requests are consumed and advance the pointer, but never raise the write enable.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         rr_ptr_q <= '0;
         o_we     <= 1'b0;
         o_wreg   <= '0;
         o_wdata  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         o_we     <= hs && (sel_wreg != '0);
         if (hs) begin
            o_wreg  <= sel_wreg;
            o_wdata <= sel_wdata;
         end
      end
   end

`ifdef RF_WB_SCOREBOARD_EN
   localparam logic [RegsNum-1:0] NoX0Mask = {{(RegsNum-1){1'b1}}, 1'b0};

   logic [RegsNum-1:0] pend_q;
   logic [RegsNum-1:0] set_mask;
   logic [RegsNum-1:0] clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (i_rsv_valid) set_mask[i_rsv_reg] = 1'b1;
      if (o_we)        clr_mask[o_wreg]    = 1'b1;
   end

   // Set is applied after clear so a fresh reservation survives a same-cycle retire.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         pend_q <= '0;
      end else begin
         pend_q <= ((pend_q & ~clr_mask) | set_mask) & NoX0Mask;
      end
   end

   assign o_pending = pend_q;
`else
   logic rsv_unused;
   assign rsv_unused = i_rsv_valid ^ (^i_rsv_reg);
   assign o_pending  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the round-robin/scoreboard rules.
module tb_rf_wb_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;

   logic                 i_clk = 1'b0;
   logic                 i_rstn = 1'b0;
   logic [N-1:0]         src_valid = '0;
   logic [N-1:0]         src_ready;
   logic [N-1:0][4:0]    src_wreg = '0;
   logic [N-1:0][DW-1:0] src_wdata = '0;
   logic [4:0]           o_wreg;
   logic [DW-1:0]        o_wdata;
   logic                 o_we;
   logic                 rsv_valid = 1'b0;
   logic [4:0]           rsv_reg = '0;
   logic [31:0]          o_pending;

   int n_err = 0;
   int n_chk = 0;

   int          m_ptr = 0;
   logic        m_we = 1'b0;
   logic [4:0]  m_wreg = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_pend = '0;
   int          last_g = -1;

   rf_wb_arbiter #(.DataWidth(DW), .NumSrc(N)) dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_src_valid (src_valid),
      .o_src_ready (src_ready),
      .i_src_wreg  (src_wreg),
      .i_src_wdata (src_wdata),
      .o_wreg      (o_wreg),
      .o_wdata     (o_wdata),
      .o_we        (o_we),
      .i_rsv_valid (rsv_valid),
      .i_rsv_reg   (rsv_reg),
      .o_pending   (o_pending)
   );

   always #5 i_clk = ~i_clk;

   function automatic int model_grant(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (ptr + k) % N;
         if (((v >> idx) & 1) != 0) return idx;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      int g;
      r = '0;
      if (i_rstn) begin
         g = model_grant(src_valid, m_ptr);
         if (g >= 0) r = N'(1) << g;
      end
      return r;
   endfunction

   // Advance one clock and update the reference model with what the edge sampled.
   task automatic tick();
      int g;
      g = i_rstn ? model_grant(src_valid, m_ptr) : -1;
      @(posedge i_clk);
      if (!i_rstn) begin
         m_ptr = 0; m_we = 1'b0; m_wreg = '0; m_wdata = '0; m_pend = '0;
      end else begin
`ifdef RF_WB_SCOREBOARD_EN
         if (m_we) m_pend[m_wreg] = 1'b0;
         if (rsv_valid && rsv_reg != 5'd0) m_pend[rsv_reg] = 1'b1;
`endif
         m_we = (g >= 0) && (src_wreg[g] != 5'd0);
         if (g >= 0) begin
            m_wreg  = src_wreg[g];
            m_wdata = src_wdata[g];
            m_ptr   = (g + 1) % N;
         end
      end
      last_g = g;
      #1;
   endtask

   task automatic do_reset();
      src_valid = '0; rsv_valid = 1'b0; i_rstn = 1'b0;
      tick();
      i_rstn = 1'b1;
   endtask

   task automatic test_reset();
      i_rstn = 1'b0; src_valid = '1;
      src_wreg[0] = 5'd1; src_wreg[1] = 5'd2; src_wreg[2] = 5'd3;
      rsv_valid = 1'b1; rsv_reg = 5'd4;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_chk++;
         if (src_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got=%b exp=000", src_ready); end
         tick();
         n_chk++;
         if (o_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b exp=0", o_we); end
         n_chk++;
         if (o_pending !== 32'h0) begin n_err++; $display("FAIL reset_pending got=%h exp=0", o_pending); end
      end
      n_chk++;
      if (o_wreg !== 5'd0 || o_wdata !== 32'h0) begin
         n_err++; $display("FAIL reset_wreg_wdata got=%0d/%h exp=0/0", o_wreg, o_wdata);
      end
      rsv_valid = 1'b0; src_valid = '0; i_rstn = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      src_valid = 3'b001; src_wreg[0] = 5'd5; src_wdata[0] = 32'hDEADBEEF;
      #1;
      n_chk++;
      if (src_ready !== 3'b001) begin n_err++; $display("FAIL single_ready got=%b exp=001", src_ready); end
      tick();
      src_valid = '0;
      n_chk++;
      if (o_we !== 1'b1 || o_wreg !== 5'd5 || o_wdata !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", o_we, o_wreg, o_wdata);
      end
      tick();
      n_chk++;
      if (o_we !== 1'b0 || o_wreg !== 5'd5 || o_wdata !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL single_idle_hold got=%b/%0d/%h exp=0/5/deadbeef", o_we, o_wreg, o_wdata);
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] exp_r;
      do_reset();
      src_valid = '1;
      for (int s = 0; s < N; s++) begin
         src_wreg[s] = 5'(s + 1); src_wdata[s] = 32'hA000_0000 + 32'(s);
      end
      for (int s = 0; s < N; s++) begin
         #1;
         exp_r = N'(1) << s;
         n_chk++;
         if (src_ready !== exp_r) begin n_err++; $display("FAIL fair_ready%0d got=%b exp=%b", s, src_ready, exp_r); end
         tick();
         src_valid[s] = 1'b0;
         n_chk++;
         if (o_we !== 1'b1 || o_wreg !== 5'(s + 1) || o_wdata !== 32'hA000_0000 + 32'(s)) begin
            n_err++; $display("FAIL fair_write%0d got=%b/%0d/%h exp=1/%0d", s, o_we, o_wreg, o_wdata, s + 1);
         end
      end
      #1;
      n_chk++;
      if (src_ready !== 3'b000) begin n_err++; $display("FAIL fair_no_grant got=%b exp=000", src_ready); end
      tick();
      n_chk++;
      if (o_we !== 1'b0) begin n_err++; $display("FAIL fair_idle_we got=%b exp=0", o_we); end
   endtask

   task automatic test_x0();
      do_reset();
      src_valid = 3'b010; src_wreg[1] = 5'd0; src_wdata[1] = 32'h1234;
      #1;
      n_chk++;
      if (src_ready !== 3'b010) begin n_err++; $display("FAIL x0_ready got=%b exp=010", src_ready); end
      tick();
      src_valid = '1;
      for (int s = 0; s < N; s++) src_wreg[s] = 5'(s + 10);
      n_chk++;
      if (o_we !== 1'b0) begin n_err++; $display("FAIL x0_we got=%b exp=0", o_we); end
      #1;
      n_chk++;
      if (src_ready !== 3'b100) begin n_err++; $display("FAIL x0_ptr_adv got=%b exp=100", src_ready); end
      tick();
      src_valid = '0;
      tick();
   endtask

   task automatic test_scoreboard();
      do_reset();
`ifdef RF_WB_SCOREBOARD_EN
      rsv_valid = 1'b1; rsv_reg = 5'd7;
      tick();
      rsv_valid = 1'b0;
      n_chk++;
      if (o_pending[7] !== 1'b1) begin n_err++; $display("FAIL sb_set7 got=%b exp=1", o_pending[7]); end
      src_valid = 3'b100; src_wreg[2] = 5'd7; src_wdata[2] = 32'h77;
      tick();
      src_valid = '0;
      n_chk++;
      if (o_we !== 1'b1 || o_wreg !== 5'd7 || o_pending[7] !== 1'b1) begin
         n_err++; $display("FAIL sb_write7 got=%b/%0d/%b exp=1/7/1", o_we, o_wreg, o_pending[7]);
      end
      tick();
      n_chk++;
      if (o_pending[7] !== 1'b0) begin n_err++; $display("FAIL sb_clear7 got=%b exp=0", o_pending[7]); end
      rsv_valid = 1'b1; rsv_reg = 5'd7;
      tick();
      rsv_valid = 1'b0;
      src_valid = 3'b001; src_wreg[0] = 5'd7; src_wdata[0] = 32'h70;
      tick();
      src_valid = '0;
      rsv_valid = 1'b1; rsv_reg = 5'd7;
      n_chk++;
      if (o_we !== 1'b1 || o_wreg !== 5'd7) begin n_err++; $display("FAIL sb_we7b got=%b/%0d exp=1/7", o_we, o_wreg); end
      tick();
      rsv_valid = 1'b0;
      n_chk++;
      if (o_pending[7] !== 1'b1) begin n_err++; $display("FAIL sb_set_wins got=%b exp=1", o_pending[7]); end
      rsv_valid = 1'b1; rsv_reg = 5'd0;
      tick();
      rsv_valid = 1'b0;
      n_chk++;
      if (o_pending !== 32'h0000_0080) begin n_err++; $display("FAIL sb_rsv_x0 got=%h exp=00000080", o_pending); end
`else
      rsv_valid = 1'b1; rsv_reg = 5'd7;
      tick();
      rsv_valid = 1'b0;
      n_chk++;
      if (o_pending !== 32'h0) begin n_err++; $display("FAIL sb_tied_off got=%h exp=0", o_pending); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      rsv_valid = 1'b1; rsv_reg = 5'd9;
      src_valid = 3'b010; src_wreg[1] = 5'd9; src_wdata[1] = 32'h99;
      #1;
      n_chk++;
      if (src_ready !== 3'b010) begin n_err++; $display("FAIL rmid_ready got=%b exp=010", src_ready); end
      tick();
      rsv_valid = 1'b0; src_valid = '1; i_rstn = 1'b0;
      n_chk++;
      if (o_we !== 1'b1) begin n_err++; $display("FAIL rmid_we_before got=%b exp=1", o_we); end
      #1;
      n_chk++;
      if (src_ready !== 3'b000) begin n_err++; $display("FAIL rmid_ready_rst got=%b exp=000", src_ready); end
      tick();
      n_chk++;
      if (o_we !== 1'b0 || o_pending !== 32'h0) begin
         n_err++; $display("FAIL rmid_cleared got=%b/%h exp=0/0", o_we, o_pending);
      end
      i_rstn = 1'b1;
      #1;
      n_chk++;
      if (src_ready !== 3'b001) begin n_err++; $display("FAIL rmid_ptr0 got=%b exp=001", src_ready); end
      src_valid = '0;
      tick();
   endtask

   task automatic test_random();
      int waitc[N];
      int g;
      logic [N-1:0] er;
      do_reset();
      for (int s = 0; s < N; s++) waitc[s] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int s = 0; s < N; s++) begin
            if (!src_valid[s] && $urandom_range(0, 99) < 55) begin
               src_valid[s] = 1'b1;
               src_wreg[s]  = 5'($urandom_range(0, 7));
               src_wdata[s] = $urandom;
            end
         end
         rsv_valid = ($urandom_range(0, 2) == 0);
         rsv_reg   = 5'($urandom_range(0, 7));
         #1;
         er = exp_ready();
         n_chk++;
         if (src_ready !== er) begin n_err++; $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, src_ready, er); end
         g = model_grant(src_valid, m_ptr);
         for (int s = 0; s < N; s++) begin
            if (s == g) begin
               n_chk++;
               if (waitc[s] > N - 1) begin n_err++; $display("FAIL rnd_starve s%0d got=%0d exp<=%0d", s, waitc[s], N - 1); end
               waitc[s] = 0;
            end else if (src_valid[s]) begin
               waitc[s]++;
            end
         end
         tick();
         if (last_g >= 0) src_valid[last_g] = 1'b0;
         n_chk++;
         if (o_we !== m_we || o_wreg !== m_wreg || o_wdata !== m_wdata) begin
            n_err++; $display("FAIL rnd_out c%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, o_we, o_wreg, o_wdata, m_we, m_wreg, m_wdata);
         end
         n_chk++;
         if (o_pending !== m_pend) begin n_err++; $display("FAIL rnd_pending c%0d got=%h exp=%h", cyc, o_pending, m_pend); end
      end
      src_valid = '0; rsv_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_x0();
      test_scoreboard();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
